// File: rtl/sparc_mem_responder.sv
// Timed big-endian byte RAM answering SPARC loads/stores with MFC/MSET pulses.
// Define SPARC_MEM_SWAP_EN to support the SWAP atomic exchange (op3 001111).
module sparc_mem_responder #(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 3
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        RAM_enable,
  input  logic [5:0]  RAM_OpCode,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        MSET,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  logic [7:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [5:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           din_q, din_d;
  logic                  rearm_q, rearm_d;
  logic                  busy_q, busy_d;
  logic [31:0]           dout_q, dout_d;
  logic                  mfc_q, mfc_d;
  logic                  mset_q, mset_d;

  logic  is_ld, is_st, is_swap, sx, op_ok;
  logic  aligned, fault, do_write;
  size_t sz;

  logic [ADDR_WIDTH-3:0] wbase;
  logic [7:0]            r0, r1, r2, r3, rbyte;
  logic [15:0]           rhalf;
  logic [31:0]           rdata;

  logic unused_addr;
  assign unused_addr = ^Address[31:ADDR_WIDTH];

  always_comb begin
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_swap = 1'b0;
    sx      = 1'b0;
    op_ok   = 1'b1;
    sz      = SZ_W;
    case (op_q)
      6'b000000: is_ld = 1'b1;
      6'b000001: begin
        is_ld = 1'b1;
        sz    = SZ_B;
      end
      6'b001001: begin
        is_ld = 1'b1;
        sz    = SZ_B;
        sx    = 1'b1;
      end
      6'b000010: begin
        is_ld = 1'b1;
        sz    = SZ_H;
      end
      6'b001010: begin
        is_ld = 1'b1;
        sz    = SZ_H;
        sx    = 1'b1;
      end
      6'b000100: is_st = 1'b1;
      6'b000101: begin
        is_st = 1'b1;
        sz    = SZ_B;
      end
      6'b000110: begin
        is_st = 1'b1;
        sz    = SZ_H;
      end
`ifdef SPARC_MEM_SWAP_EN
      6'b001111: is_swap = 1'b1;
`endif
      default: op_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (sz)
      SZ_B:    aligned = 1'b1;
      SZ_H:    aligned = ~addr_q[0];
      default: aligned = (addr_q[1:0] == 2'b00);
    endcase
  end

  assign fault    = ~op_ok | ~aligned;
  assign do_write = (state_q == RESP) & ~fault & (is_st | is_swap);

  assign wbase = addr_q[ADDR_WIDTH-1:2];
  assign r0    = mem[{wbase, 2'b00}];
  assign r1    = mem[{wbase, 2'b01}];
  assign r2    = mem[{wbase, 2'b10}];
  assign r3    = mem[{wbase, 2'b11}];
  assign rhalf = addr_q[1] ? {r2, r3} : {r0, r1};

  always_comb begin
    case (addr_q[1:0])
      2'b00:   rbyte = r0;
      2'b01:   rbyte = r1;
      2'b10:   rbyte = r2;
      default: rbyte = r3;
    endcase
  end

  always_comb begin
    case (sz)
      SZ_B: rdata = sx ? {{24{rbyte[7]}}, rbyte}
                       : {24'h0, rbyte};
      SZ_H: rdata = sx ? {{16{rhalf[15]}}, rhalf}
                       : {16'h0, rhalf};
      default: rdata = {r0, r1, r2, r3};
    endcase
  end

  // Storage is deliberately not reset; only the RESP cycle may write it.
  always_ff @(posedge Clk) begin
    if (do_write) begin
      case (sz)
        SZ_B: mem[addr_q] <= din_q[7:0];
        SZ_H: begin
          mem[{addr_q[ADDR_WIDTH-1:1], 1'b0}] <= din_q[15:8];
          mem[{addr_q[ADDR_WIDTH-1:1], 1'b1}] <= din_q[7:0];
        end
        default: begin
          mem[{wbase, 2'b00}] <= din_q[31:24];
          mem[{wbase, 2'b01}] <= din_q[23:16];
          mem[{wbase, 2'b10}] <= din_q[15:8];
          mem[{wbase, 2'b11}] <= din_q[7:0];
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rearm_d = rearm_q | ~RAM_enable;
    busy_d  = busy_q;
    dout_d  = dout_q;
    mfc_d   = 1'b0;
    mset_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (RAM_enable && rearm_q) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
          op_d    = RAM_OpCode;
          addr_d  = Address[ADDR_WIDTH-1:0];
          din_d   = DataIn;
          rearm_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        mfc_d   = ~fault;
        mset_d  = fault;
        if (!fault && (is_ld || is_swap)) dout_d = rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 6'd0;
      addr_q  <= '0;
      din_q   <= 32'd0;
      rearm_q <= 1'b1;
      busy_q  <= 1'b0;
      dout_q  <= 32'd0;
      mfc_q   <= 1'b0;
      mset_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rearm_q <= rearm_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      mset_q  <= mset_d;
    end
  end

  assign DataOut = dout_q;
  assign MFC     = mfc_q;
  assign MSET    = mset_q;
  assign busy    = busy_q;

endmodule
